// File: rtl/ro_window_ctrl.sv
// Measurement-window controller for the RO PUF array: clears the edge counters,
// gates per-channel count enables for a latched window length, then settles and reports.
module ro_window_ctrl #(
   parameter int N_CH       = 8,
   parameter int WIN_W      = 24,
   parameter int SETTLE_CYC = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [WIN_W-1:0]  win_len,
   input  logic [N_CH-1:0]   ch_mask,
   output logic [N_CH-1:0]   ce_out,
   output logic              cnt_clr,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [WIN_W-1:0]  elapsed
);

   localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, DONE} state_t;

   state_t            state, state_nxt;
   logic [WIN_W-1:0]  len_q, len_nxt;
   logic [N_CH-1:0]   mask_q, mask_nxt;
   logic [WIN_W-1:0]  elapsed_nxt;
   logic              aborted_nxt;
   logic [SC_W-1:0]   scnt, scnt_nxt;
   logic [N_CH-1:0]   ce_nxt;
   logic              clr_nxt, busy_nxt, done_nxt;
   logic              accept;

   assign accept = start & ~abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         len_q   <= '0;
         mask_q  <= '0;
         scnt    <= '0;
         ce_out  <= '0;
         cnt_clr <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         aborted <= 1'b0;
         elapsed <= '0;
      end else begin
         state   <= state_nxt;
         len_q   <= len_nxt;
         mask_q  <= mask_nxt;
         scnt    <= scnt_nxt;
         ce_out  <= ce_nxt;
         cnt_clr <= clr_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         aborted <= aborted_nxt;
         elapsed <= elapsed_nxt;
      end
   end

   // Outputs are registered, so they are derived from the next state rather than the current one.
   always_comb begin
      state_nxt   = state;
      len_nxt     = len_q;
      mask_nxt    = mask_q;
      elapsed_nxt = elapsed;
      aborted_nxt = aborted;
      scnt_nxt    = '0;

      case (state)
         IDLE, DONE: begin
            if (accept) begin
               state_nxt   = CLEAR;
               len_nxt     = win_len;
               mask_nxt    = ch_mask;
               aborted_nxt = 1'b0;
               elapsed_nxt = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         CLEAR: begin
            if (abort) begin
               state_nxt   = SETTLE;
               aborted_nxt = 1'b1;
            end else if (len_q != '0) begin
               state_nxt = RUN;
            end else begin
               state_nxt = SETTLE;
            end
         end
         RUN: begin
            // elapsed doubles as the run counter; it never exceeds len_q, so no wrap
            elapsed_nxt = elapsed + 1'b1;
            if (abort) begin
               state_nxt   = SETTLE;
               aborted_nxt = 1'b1;
            end else if (elapsed_nxt == len_q) begin
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (scnt == SC_LAST) state_nxt = DONE;
            else                 scnt_nxt  = scnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase

      ce_nxt   = (state_nxt == RUN) ? mask_nxt : '0;
      clr_nxt  = (state_nxt == CLEAR);
      busy_nxt = (state_nxt == CLEAR) || (state_nxt == RUN) || (state_nxt == SETTLE);
      done_nxt = (state_nxt == DONE);
   end

endmodule
